// File: rtl/video_compositor.sv
// -----------------------------------------------------------------------------
// video_compositor
//
// Final video stage of the whack-a-mole display. The xvga timing signals
// (hsync, vsync, blank, hcount, vcount) are delayed by PIPE_DEPTH registers so
// they line up with the sprite ROM outputs. This stage then picks the visible
// layer from the game state, blinks the start prompt at frame rate, flashes a
// red border after a whack, and registers the result onto the 4-bit VGA pins.
//
// Optional feature: define GRID_OVERLAY_EN to draw a 2-pixel brown outline
// around the eight hole rectangles during play. Left undefined, no outline
// logic is built and background shows there instead.
//
// Ports
//   clk            pixel clock (same clock as the xvga generator)
//   reset          asynchronous, active-high
//   state[3:0]     game FSM state (0 = IDLE, 6 = WHACK, 8 = OVER)
//   hcount[10:0]   xvga pixel number
//   vcount[9:0]    xvga line number
//   hsync_in       xvga hsync, active low
//   vsync_in       xvga vsync, active low
//   blank_in       xvga blanking
//   mole_pixel     displaymole pixel, 0 = transparent
//   title_pixel    title banner pixel, 0 = transparent
//   start_pixel    start prompt pixel, 0 = transparent
//   gameover_pixel game-over screen pixel, 0 = transparent
//   vga_r/g/b      4-bit colour, top nibble of each 8-bit channel
//   vga_hs, vga_vs sync outputs, active low
//   frame_pulse    one-cycle pulse when the delayed vsync falls
// -----------------------------------------------------------------------------
module video_compositor #(
  parameter int          PIPE_DEPTH   = 3,
  parameter int          BLINK_FRAMES = 30,
  parameter int          FLASH_FRAMES = 12,
  parameter int          BORDER       = 8,
  parameter logic [23:0] BG_COLOR     = 24'h2F7F1F,
  parameter logic [23:0] FLASH_COLOR  = 24'hFF0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  state,
  input  logic [10:0] hcount,
  input  logic [9:0]  vcount,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        blank_in,
  input  logic [23:0] mole_pixel,
  input  logic [23:0] title_pixel,
  input  logic [23:0] start_pixel,
  input  logic [23:0] gameover_pixel,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        frame_pulse
);

  localparam int BW = $clog2(2 * BLINK_FRAMES);
  localparam int FW = $clog2(FLASH_FRAMES + 1);

  localparam logic [3:0] ST_IDLE  = 4'd0;
  localparam logic [3:0] ST_WHACK = 4'd6;
  localparam logic [3:0] ST_OVER  = 4'd8;

  // Only the top nibble of each channel reaches the pins.
  localparam logic [11:0] BG_RGB    = {BG_COLOR[23:20], BG_COLOR[15:12], BG_COLOR[7:4]};
  localparam logic [11:0] FLASH_RGB = {FLASH_COLOR[23:20], FLASH_COLOR[15:12], FLASH_COLOR[7:4]};

  // ---------------------------------------------------------------------------
  // xvga timing delay line
  // ---------------------------------------------------------------------------
  logic [PIPE_DEPTH-1:0] hs_pipe, vs_pipe, bl_pipe;
  logic [10:0]           hc_pipe [PIPE_DEPTH];
  logic [9:0]            vc_pipe [PIPE_DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hs_pipe <= '1;
      vs_pipe <= '1;
      bl_pipe <= '1;
      for (int i = 0; i < PIPE_DEPTH; i++) begin
        hc_pipe[i] <= '0;
        vc_pipe[i] <= '0;
      end
    end else begin
      hs_pipe[0] <= hsync_in;
      vs_pipe[0] <= vsync_in;
      bl_pipe[0] <= blank_in;
      hc_pipe[0] <= hcount;
      vc_pipe[0] <= vcount;
      for (int i = 1; i < PIPE_DEPTH; i++) begin
        hs_pipe[i] <= hs_pipe[i-1];
        vs_pipe[i] <= vs_pipe[i-1];
        bl_pipe[i] <= bl_pipe[i-1];
        hc_pipe[i] <= hc_pipe[i-1];
        vc_pipe[i] <= vc_pipe[i-1];
      end
    end
  end

  logic        hs_d, vs_d, bl_d;
  logic [10:0] hc_d;
  logic [9:0]  vc_d;

  assign hs_d = hs_pipe[PIPE_DEPTH-1];
  assign vs_d = vs_pipe[PIPE_DEPTH-1];
  assign bl_d = bl_pipe[PIPE_DEPTH-1];
  assign hc_d = hc_pipe[PIPE_DEPTH-1];
  assign vc_d = vc_pipe[PIPE_DEPTH-1];

  // vga_vs already holds last cycle's delayed vsync, so it doubles as the
  // edge-detect history register for the frame boundary.
  logic frame_edge;
  assign frame_edge = vga_vs & ~vs_d;

  // ---------------------------------------------------------------------------
  // Frame-rate counters
  // ---------------------------------------------------------------------------
  logic [BW-1:0] blink_cnt;
  logic [FW-1:0] flash_cnt;
  logic [3:0]    prev_state;
  logic          whack_entry;
  logic          blink_on;

  assign whack_entry = (prev_state != ST_WHACK) && (state == ST_WHACK);
  assign blink_on    = blink_cnt < BW'(BLINK_FRAMES);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_cnt  <= '0;
      flash_cnt  <= '0;
      prev_state <= ST_IDLE;
    end else begin
      prev_state <= state;
      if (frame_edge) begin
        blink_cnt <= (blink_cnt == BW'(2 * BLINK_FRAMES - 1)) ? '0 : blink_cnt + BW'(1);
      end
      // A fresh whack restarts the flash even if a frame boundary lands
      // on the same cycle.
      if (whack_entry) begin
        flash_cnt <= FW'(FLASH_FRAMES);
      end else if (frame_edge && (flash_cnt != '0)) begin
        flash_cnt <= flash_cnt - FW'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Layer select
  // ---------------------------------------------------------------------------
  logic        on_border;
  logic [11:0] pix;

  assign on_border = (hc_d < 11'(BORDER)) || (hc_d >= 11'(1024 - BORDER)) ||
                     (vc_d < 10'(BORDER)) || (vc_d >= 10'(768 - BORDER));

`ifdef GRID_OVERLAY_EN
  localparam logic [23:0] GRID_COLOR = 24'h402000;
  localparam logic [11:0] GRID_RGB   = {GRID_COLOR[23:20], GRID_COLOR[15:12], GRID_COLOR[7:4]};

  // Hole rectangles are 212x256 on a 341-pixel column pitch starting at x=65
  // and a 256-line row pitch; the centre slot carries no outline.
  int   gx, gy;
  logic on_grid;

  assign gx = {21'd0, hc_d};
  assign gy = {22'd0, vc_d};

  always_comb begin
    on_grid = 1'b0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        if (!(r == 1 && c == 1) &&
            gx >= 65 + 341 * c && gx < 65 + 341 * c + 212 &&
            gy >= 256 * r      && gy < 256 * r + 256 &&
            (gx < 65 + 341 * c + 2 || gx >= 65 + 341 * c + 210 ||
             gy < 256 * r + 2      || gy >= 256 * r + 254)) begin
          on_grid = 1'b1;
        end
      end
    end
  end
`endif

  always_comb begin
    pix = BG_RGB;
    if (bl_d) begin
      pix = '0;
    end else if (state == ST_IDLE) begin
      if (title_pixel != '0) begin
        pix = {title_pixel[23:20], title_pixel[15:12], title_pixel[7:4]};
      end else if (blink_on && (start_pixel != '0)) begin
        pix = {start_pixel[23:20], start_pixel[15:12], start_pixel[7:4]};
      end
    end else if (state == ST_OVER) begin
      if (gameover_pixel != '0) begin
        pix = {gameover_pixel[23:20], gameover_pixel[15:12], gameover_pixel[7:4]};
      end
    end else begin
      if ((flash_cnt != '0) && on_border) begin
        pix = FLASH_RGB;
      end else if (mole_pixel != '0) begin
        pix = {mole_pixel[23:20], mole_pixel[15:12], mole_pixel[7:4]};
`ifdef GRID_OVERLAY_EN
      end else if (on_grid) begin
        pix = GRID_RGB;
`endif
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output stage: colour and sync registered together
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
      vga_hs      <= 1'b1;
      vga_vs      <= 1'b1;
      frame_pulse <= 1'b0;
    end else begin
      vga_r       <= pix[11:8];
      vga_g       <= pix[7:4];
      vga_b       <= pix[3:0];
      vga_hs      <= hs_d;
      vga_vs      <= vs_d;
      frame_pulse <= frame_edge;
    end
  end

endmodule

// File: tb/tb_video_compositor.sv
// -----------------------------------------------------------------------------
// tb_video_compositor
//
// Drives video_compositor with a miniature xvga raster (16 clocks per line,
// 8 lines per frame, vsync low on line 6) plus directed and random pixel/state
// inputs. A reference model tracks the delayed timing in a queue, counts frames
// and flash frames as plain integers, and predicts every output cycle.
// Define GRID_OVERLAY_EN for both DUT and bench to cover the outline option.
// -----------------------------------------------------------------------------
module tb_video_compositor;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  state;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic        hsync_in, vsync_in, blank_in;
  logic [23:0] mole_pixel, title_pixel, start_pixel, gameover_pixel;
  logic [3:0]  vga_r, vga_g, vga_b;
  logic        vga_hs, vga_vs, frame_pulse;

  always #5 clk = ~clk;

  video_compositor dut (
    .clk            (clk),
    .reset          (reset),
    .state          (state),
    .hcount         (hcount),
    .vcount         (vcount),
    .hsync_in       (hsync_in),
    .vsync_in       (vsync_in),
    .blank_in       (blank_in),
    .mole_pixel     (mole_pixel),
    .title_pixel    (title_pixel),
    .start_pixel    (start_pixel),
    .gameover_pixel (gameover_pixel),
    .vga_r          (vga_r),
    .vga_g          (vga_g),
    .vga_b          (vga_b),
    .vga_hs         (vga_hs),
    .vga_vs         (vga_vs),
    .frame_pulse    (frame_pulse)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        bl;
    logic [10:0] hc;
    logic [9:0]  vc;
  } tsample_t;

  localparam int LAT = 3;   // timing delay stages ahead of the output register

  tsample_t    tq[$];
  tsample_t    m_now, m_old, m_d, m_rst;
  logic        m_ev;
  int          m_frames;
  int          m_flash;
  logic [3:0]  m_prev;
  logic [11:0] exp_rgb = 12'h000;
  logic        exp_hs  = 1'b1;
  logic        exp_vs  = 1'b1;
  logic        exp_fp  = 1'b0;

  function automatic logic [11:0] rgb12(input logic [23:0] p);
    return {p[23:20], p[15:12], p[7:4]};
  endfunction

`ifdef GRID_OVERLAY_EN
  function automatic logic on_outline(input int x, input int y);
    int xs[3] = '{65, 406, 747};
    int ys[3] = '{0, 256, 512};
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        if (!(r == 1 && c == 1)) begin
          if (x >= xs[c] && x <= xs[c] + 211 && y >= ys[r] && y <= ys[r] + 255 &&
              (x - xs[c] < 2 || xs[c] + 211 - x < 2 || y - ys[r] < 2 || ys[r] + 255 - y < 2))
            return 1'b1;
        end
    return 1'b0;
  endfunction
`endif

  function automatic logic [23:0] ref_pixel(input logic [3:0] st, input tsample_t d,
                                            input bit blink_on, input bit flash_on);
    bit edge_px;
    if (d.bl) return 24'h0;
    if (st == 4'd0) begin
      if (title_pixel != 0) return title_pixel;
      if (blink_on && start_pixel != 0) return start_pixel;
      return 24'h2F7F1F;
    end
    if (st == 4'd8) return (gameover_pixel != 0) ? gameover_pixel : 24'h2F7F1F;
    edge_px = (d.hc < 8) || (d.hc > 1015) || (d.vc < 8) || (d.vc > 759);
    if (flash_on && edge_px) return 24'hFF0000;
    if (mole_pixel != 0) return mole_pixel;
`ifdef GRID_OVERLAY_EN
    if (on_outline(int'(d.hc), int'(d.vc))) return 24'h402000;
`endif
    return 24'h2F7F1F;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_rst.hs = 1'b1; m_rst.vs = 1'b1; m_rst.bl = 1'b1; m_rst.hc = '0; m_rst.vc = '0;
      tq = {};
      for (int i = 0; i <= LAT; i++) tq.push_back(m_rst);
      m_frames = 0;
      m_flash  = 0;
      m_prev   = 4'd0;
      exp_rgb  = 12'h000;
      exp_hs   = 1'b1;
      exp_vs   = 1'b1;
      exp_fp   = 1'b0;
    end else begin
      m_now.hs = hsync_in; m_now.vs = vsync_in; m_now.bl = blank_in;
      m_now.hc = hcount;   m_now.vc = vcount;
      tq.push_back(m_now);
      m_old = tq[0];          // delayed timing one cycle earlier
      m_d   = tq[1];          // delayed timing seen by this edge
      m_ev  = m_old.vs && !m_d.vs;
      exp_rgb = rgb12(ref_pixel(state, m_d, (m_frames % 60) < 30, m_flash != 0));
      exp_hs  = m_d.hs;
      exp_vs  = m_d.vs;
      exp_fp  = m_ev;
      if (m_ev) m_frames++;
      if (m_prev != 4'd6 && state == 4'd6) m_flash = 12;
      else if (m_ev && m_flash > 0) m_flash--;
      m_prev = state;
      void'(tq.pop_front());
    end
  end

  // Scoreboard: compare every cycle on the falling edge.
  always @(negedge clk) begin
    if (reset) begin
      check("rst_rgb", {vga_r, vga_g, vga_b}, 12'h000);
      check("rst_hs", vga_hs, 1'b1);
      check("rst_vs", vga_vs, 1'b1);
      check("rst_fp", frame_pulse, 1'b0);
    end else begin
      check("rgb", {vga_r, vga_g, vga_b}, exp_rgb);
      check("hs", vga_hs, exp_hs);
      check("vs", vga_vs, exp_vs);
      check("frame_pulse", frame_pulse, exp_fp);
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  int gpos = 0, gh = 0, gv = 0, gframes = 0;

  task automatic tick(input bit gen);
    @(posedge clk);
    #1;
    if (gen) begin
      gh = gpos % 16;
      gv = (gpos / 16) % 8;
      hsync_in = !(gh >= 12 && gh < 14);
      if (vsync_in && gv == 6) gframes++;
      vsync_in = (gv != 6);
      blank_in = (gh >= 10) || (gv >= 6);
      gpos++;
    end
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    hsync_in = 1'b1; vsync_in = 1'b1; blank_in = 1'b1;
    tick(0);
    tick(0);
    reset = 1'b0;
    gpos = 0; gframes = 0;
  endtask

  function automatic logic [10:0] pick_h();
    case ($urandom_range(0, 4))
      0: return 11'($urandom_range(0, 9));
      1: return 11'($urandom_range(1014, 1023));
      2: return 11'($urandom_range(60, 70));
      3: return 11'($urandom_range(270, 280));
      default: return 11'($urandom_range(0, 2047));
    endcase
  endfunction

  function automatic logic [9:0] pick_v();
    case ($urandom_range(0, 4))
      0: return 10'($urandom_range(0, 9));
      1: return 10'($urandom_range(758, 767));
      2: return 10'($urandom_range(250, 260));
      default: return 10'($urandom_range(0, 1023));
    endcase
  endfunction

  function automatic logic [23:0] pick_pix();
    return ($urandom_range(0, 3) == 0) ? 24'h0 : 24'($urandom);
  endfunction

  function automatic logic [3:0] pick_state();
    case ($urandom_range(0, 5))
      0: return 4'd0;
      1: return 4'd2;
      2, 3: return 4'd6;
      4: return 4'd8;
      default: return 4'($urandom_range(0, 15));
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  int lat;
  int left;

  initial begin
    reset = 1'b0;
    state = 4'd0; hcount = '0; vcount = '0;
    hsync_in = 1'b1; vsync_in = 1'b1; blank_in = 1'b1;
    mole_pixel = '0; title_pixel = '0; start_pixel = '0; gameover_pixel = '0;
    #2 reset = 1'b1;
    tick(0); tick(0); tick(0);
    reset = 1'b0;

    // Reset mid-line while the raster is running.
    title_pixel = 24'h123456; hcount = 11'd100; vcount = 10'd100;
    repeat (40) tick(1);
    reset = 1'b1;
    #1;
    check("midline_rst_rgb", {vga_r, vga_g, vga_b}, 12'h000);
    check("midline_rst_hs", vga_hs, 1'b1);
    check("midline_rst_vs", vga_vs, 1'b1);
    repeat (3) tick(1);
    reset = 1'b0;

    // hsync latency after release.
    hsync_in = 1'b1; vsync_in = 1'b1; blank_in = 1'b1;
    repeat (6) tick(0);
    hsync_in = 1'b0;
    lat = 0;
    for (int k = 1; k <= 10; k++) begin
      tick(0);
      if (!vga_hs && lat == 0) lat = k;
    end
    check("hs_latency", lat, 4);
    hsync_in = 1'b1;

    // Mole over grass.
    blank_in = 1'b0; state = 4'd2; hcount = 11'd100; vcount = 10'd100;
    mole_pixel = 24'hA0B0C0;
    repeat (4) tick(0);
    check("mole_opaque", {vga_r, vga_g, vga_b}, 12'hABC);
    mole_pixel = 24'h0;
    repeat (4) tick(0);
    check("mole_clear", {vga_r, vga_g, vga_b}, 12'h271);

    // Blanking beats every layer.
    blank_in = 1'b1;
    mole_pixel = 24'hFFFFFF; title_pixel = 24'hFFFFFF;
    start_pixel = 24'hFFFFFF; gameover_pixel = 24'hFFFFFF;
    for (int k = 1; k <= 8; k++) begin
      state = (k % 4 == 0) ? 4'd0 : (k % 4 == 1) ? 4'd2 : (k % 4 == 2) ? 4'd6 : 4'd8;
      tick(0);
      if (k >= 4) check("blank", {vga_r, vga_g, vga_b}, 12'h000);
    end

    // Outline pixel at the left edge of the first hole.
    blank_in = 1'b0; state = 4'd2; hcount = 11'd65; vcount = 10'd100;
    mole_pixel = 24'h0;
    repeat (4) tick(0);
`ifdef GRID_OVERLAY_EN
    check("grid_edge", {vga_r, vga_g, vga_b}, 12'h420);
`else
    check("grid_edge", {vga_r, vga_g, vga_b}, 12'h271);
`endif

    // Start prompt blink across the 60-frame wrap.
    pulse_reset();
    state = 4'd0; title_pixel = 24'h0; start_pixel = 24'hF0F0F0;
    hcount = 11'd100; vcount = 10'd100;
    for (int c = 0; c < 62 * 128; c++) begin
      tick(1);
      if (gv == 2 && gh == 8)
        check("blink", {vga_r, vga_g, vga_b}, ((gframes % 60) < 30) ? 12'hFFF : 12'h271);
    end

    // Whack flash: enter 6, leave for one frame after 5, re-enter.
    state = 4'd2; mole_pixel = 24'h0;
    repeat (128) tick(1);
    left = 0;
    for (int k = 0; k < 22; k++) begin
      for (int c = 0; c < 128; c++) begin
        tick(1);
        if (c == 0) begin
          if (k != 5 && state != 4'd6) left = 12;
          state = (k == 5) ? 4'd2 : 4'd6;
        end
        hcount = (gv <= 2) ? 11'd3 : 11'd500;
        vcount = 10'd100;
        if (gv == 2 && gh == 8)
          check("flash_border", {vga_r, vga_g, vga_b}, (left != 0) ? 12'hF00 : 12'h271);
        if (gv == 4 && gh == 8)
          check("flash_inner", {vga_r, vga_g, vga_b}, 12'h271);
        if (gv == 6 && gh == 0 && left > 0) left--;
      end
    end

    // Random traffic against the model, with one reset partway through.
    for (int c = 0; c < 6000; c++) begin
      tick(1);
      if ($urandom_range(0, 99) < 2) state = pick_state();
      mole_pixel     = pick_pix();
      title_pixel    = pick_pix();
      start_pixel    = pick_pix();
      gameover_pixel = pick_pix();
      hcount         = pick_h();
      vcount         = pick_v();
      if (c == 3000) pulse_reset();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
